// File: rtl/serial_gate_pkg.sv
// serial_gate_pkg: shared types for the bit-serial gate reducer.
//   gate_op_t       - 2-bit gate select (AND, OR, XOR, NAND)
//   reducer_state_t - reducer FSM states (IDLE, ACC, HOLD)
//   len_width()     - width needed to hold a count of 0..max_len
package serial_gate_pkg;

   typedef enum logic [1:0] {
      GATE_AND  = 2'b00,
      GATE_OR   = 2'b01,
      GATE_XOR  = 2'b10,
      GATE_NAND = 2'b11
   } gate_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      HOLD = 2'd2
   } reducer_state_t;

   function automatic int unsigned len_width(input int unsigned max_len);
      return $clog2(max_len + 1);
   endfunction

endpackage

// File: rtl/serial_gate_reducer_if.sv
// serial_gate_reducer_if: beat input and result output handshakes of the reducer.
//   in_valid/in_ready   - input beat handshake
//   in_data/in_last     - sample bit and end-of-packet marker
//   in_op               - gate select, used on the first beat of a packet
//   out_valid/out_ready - result handshake
//   out_data/out_len    - reduced bit and saturated beat count
//   out_err             - packet exceeded MAX_LEN beats
// master modport: upstream/downstream side; slave modport: the reducer.
interface serial_gate_reducer_if #(
   parameter int unsigned MAX_LEN = 16
);
   localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

   logic             in_valid;
   logic             in_data;
   logic             in_last;
   logic [1:0]       in_op;
   logic             in_ready;
   logic             out_valid;
   logic             out_data;
   logic [LEN_W-1:0] out_len;
   logic             out_err;
   logic             out_ready;

   modport master (
      output in_valid, in_data, in_last, in_op, out_ready,
      input  in_ready, out_valid, out_data, out_len, out_err
   );

   modport slave (
      input  in_valid, in_data, in_last, in_op, out_ready,
      output in_ready, out_valid, out_data, out_len, out_err
   );

endinterface

// File: rtl/serial_gate_reducer_gate_op_cell.sv
// gate_mux2: 2:1 mux primitive of the gate library.
//   d0, d1 - data inputs; s - select; y - s ? d1 : d0
module gate_mux2 (
   input  logic d0,
   input  logic d1,
   input  logic s,
   output logic y
);
   assign y = s ? d1 : d0;
endmodule

// gate_op_cell: combinational 2-input gate with selectable function,
// built only from gate_mux2 instances and constants.
//   a, b - operands; op - gate select; y - gate(op, a, b)
module gate_op_cell
   import serial_gate_pkg::*;
(
   input  logic     a,
   input  logic     b,
   input  gate_op_t op,
   output logic     y
);
   logic [1:0] w_sel;
   logic       w_not_a;
   logic       w_and;
   logic       w_or;
   logic       w_xor;
   logic       w_nand;
   logic       w_lo;
   logic       w_hi;

   assign w_sel = op;

   // ~a: pick constant 1 when a=0, constant 0 when a=1
   gate_mux2 u_not  (.d0(1'b1), .d1(1'b0),    .s(a), .y(w_not_a));
   // each gate is a mux steered by b between a, ~a and constants
   gate_mux2 u_and  (.d0(1'b0), .d1(a),       .s(b), .y(w_and));
   gate_mux2 u_or   (.d0(a),    .d1(1'b1),    .s(b), .y(w_or));
   gate_mux2 u_xor  (.d0(a),    .d1(w_not_a), .s(b), .y(w_xor));
   gate_mux2 u_nand (.d0(1'b1), .d1(w_not_a), .s(b), .y(w_nand));

   // 4:1 function select as a two-level mux tree
   gate_mux2 u_lo   (.d0(w_and), .d1(w_or),   .s(w_sel[0]), .y(w_lo));
   gate_mux2 u_hi   (.d0(w_xor), .d1(w_nand), .s(w_sel[0]), .y(w_hi));
   gate_mux2 u_out  (.d0(w_lo),  .d1(w_hi),   .s(w_sel[1]), .y(y));

endmodule

// File: rtl/serial_gate_reducer.sv
// serial_gate_reducer: folds a packet of single-bit beats with a selectable
// 2-input gate and presents one result per packet.
//   clk - clock, rising edge
//   rst - asynchronous active-high reset
//   bus - serial_gate_reducer_if.slave: beat input, result output
// Optional overflow flag: define SERIAL_GATE_REDUCER_ERR_EN to build the err
// flop; otherwise out_err is tied low.
module serial_gate_reducer
   import serial_gate_pkg::*;
#(
   parameter int unsigned MAX_LEN = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   serial_gate_reducer_if.slave  bus
);
   localparam int unsigned     LEN_W   = len_width(MAX_LEN);
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

   reducer_state_t   r_state;
   gate_op_t         r_op;
   logic             r_acc;
   logic [LEN_W-1:0] r_len;
   logic             r_in_ready;
   logic             r_out_valid;
   logic             r_out_data;
   logic [LEN_W-1:0] r_out_len;

   logic             w_accept;
   logic             w_take;
   logic             w_sat;
   logic             w_fold;
   logic [LEN_W-1:0] w_len_next;

   assign w_accept   = bus.in_valid & r_in_ready;
   assign w_take     = r_out_valid & bus.out_ready;
   assign w_sat      = (r_len >= LEN_MAX);
   assign w_len_next = w_sat ? LEN_MAX : r_len + LEN_W'(1);

   // one gate cell shared by every beat of the fold
   gate_op_cell u_fold (
      .a  (r_acc),
      .b  (bus.in_data),
      .op (r_op),
      .y  (w_fold)
   );

   // FSM, op latch, accumulator, length counter and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_op        <= GATE_AND;
         r_acc       <= 1'b0;
         r_len       <= '0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= 1'b0;
         r_out_len   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_in_ready <= 1'b1;
               if (w_accept) begin
                  r_op  <= gate_op_t'(bus.in_op);
                  r_acc <= bus.in_data;
                  r_len <= LEN_W'(1);
                  if (bus.in_last) begin
                     r_state     <= HOLD;
                     r_in_ready  <= 1'b0;
                     r_out_valid <= 1'b1;
                     r_out_data  <= bus.in_data;
                     r_out_len   <= LEN_W'(1);
                  end else begin
                     r_state <= ACC;
                  end
               end
            end
            ACC: begin
               // in_op is not looked at here; the first beat's op is kept
               if (w_accept) begin
                  r_acc <= w_fold;
                  r_len <= w_len_next;
                  if (bus.in_last) begin
                     r_state     <= HOLD;
                     r_in_ready  <= 1'b0;
                     r_out_valid <= 1'b1;
                     r_out_data  <= w_fold;
                     r_out_len   <= w_len_next;
                  end
               end
            end
            HOLD: begin
               if (w_take) begin
                  r_state     <= IDLE;
                  r_in_ready  <= 1'b1;
                  r_out_valid <= 1'b0;
                  r_out_data  <= 1'b0;
                  r_out_len   <= '0;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
               r_out_data  <= 1'b0;
               r_out_len   <= '0;
            end
         endcase
      end
   end

`ifdef SERIAL_GATE_REDUCER_ERR_EN
   logic r_err;
   logic r_out_err;

   // overflow: any accepted beat while the count is already at MAX_LEN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err     <= 1'b0;
         r_out_err <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_err     <= 1'b0;
                  r_out_err <= 1'b0;
               end
            end
            ACC: begin
               if (w_accept) begin
                  r_err <= r_err | w_sat;
                  if (bus.in_last) begin
                     r_out_err <= r_err | w_sat;
                  end
               end
            end
            HOLD: begin
               if (w_take) begin
                  r_out_err <= 1'b0;
               end
            end
            default: begin
               r_err     <= 1'b0;
               r_out_err <= 1'b0;
            end
         endcase
      end
   end

   assign bus.out_err = r_out_err;
`else
   assign bus.out_err = 1'b0;
`endif

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_len   = r_out_len;

endmodule

// File: tb/tb_serial_gate_reducer.sv
// Testbench for serial_gate_reducer: table-driven packets with a result
// scoreboard, plus hand-written reset and power-up sequences.
module tb_serial_gate_reducer;
   import serial_gate_pkg::*;

   localparam int unsigned MAX_LEN = 4;
`ifdef SERIAL_GATE_REDUCER_ERR_EN
   localparam bit ERR_ON = 1'b1;
`else
   localparam bit ERR_ON = 1'b0;
`endif

   typedef struct {
      logic [1:0] op0;
      logic [1:0] op1;
      int         n;
      logic [7:0] d;
      int         hold;
      int         gap;
      logic       ed;
      int         elen;
      logic       ovf;
   } vec_t;

   typedef struct {
      logic d;
      int   len;
      logic err;
   } res_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   res_t sb_q[$];
   vec_t vecs[12];

   always #5 clk = ~clk;

   serial_gate_reducer_if #(.MAX_LEN(MAX_LEN)) bus ();

   serial_gate_reducer #(.MAX_LEN(MAX_LEN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_beat(input logic d, input logic last, input logic [1:0] op);
      int w;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = last;
      bus.in_op    = op;
      w = 0;
      while (!bus.in_ready && w < 20) begin
         step();
         w++;
      end
      if (w >= 20) chk("ready_timeout", 0, 1);
      step();
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input string nm);
      res_t e;
      e.d   = v.ed;
      e.len = v.elen;
      e.err = v.ovf & ERR_ON;
      bus.out_ready = (v.hold == 0);
      for (int i = 0; i < v.n; i++) begin
         if (i > 0) begin
            for (int g = 0; g < v.gap; g++) begin
               step();
               chk({nm, "_stall_ready"}, int'(bus.in_ready), 1);
               chk({nm, "_stall_valid"}, int'(bus.out_valid), 0);
            end
         end
         if (i == v.n - 1) sb_q.push_back(e);
         drive_beat(v.d[i], i == v.n - 1, (i == 0) ? v.op0 : v.op1);
      end
      chk({nm, "_valid"}, int'(bus.out_valid), 1);
      chk({nm, "_data"},  int'(bus.out_data),  int'(e.d));
      chk({nm, "_len"},   int'(bus.out_len),   e.len);
      chk({nm, "_err"},   int'(bus.out_err),   int'(e.err));
      chk({nm, "_hold_ready"}, int'(bus.in_ready), 0);
      for (int h = 0; h < v.hold; h++) begin
         step();
         chk({nm, "_held_valid"}, int'(bus.out_valid), 1);
         chk({nm, "_held_data"},  int'(bus.out_data),  int'(e.d));
         chk({nm, "_held_len"},   int'(bus.out_len),   e.len);
         chk({nm, "_held_ready"}, int'(bus.in_ready),  0);
      end
      bus.out_ready = 1'b1;
      step();
      chk({nm, "_idle_valid"}, int'(bus.out_valid), 0);
      chk({nm, "_idle_data"},  int'(bus.out_data),  0);
      chk({nm, "_idle_len"},   int'(bus.out_len),   0);
      chk({nm, "_idle_err"},   int'(bus.out_err),   0);
      chk({nm, "_idle_ready"}, int'(bus.in_ready),  1);
      bus.out_ready = 1'b0;
   endtask

   // scoreboard: every result taken must match the oldest expected one
   always @(negedge clk) begin : mon
      res_t e;
      if (bus.out_valid && bus.out_ready) begin
         if (sb_q.size() == 0) begin
            chk("sb_unexpected", 1, 0);
         end else begin
            e = sb_q.pop_front();
            chk("sb_data", int'(bus.out_data), int'(e.d));
            chk("sb_len",  int'(bus.out_len),  e.len);
            chk("sb_err",  int'(bus.out_err),  int'(e.err));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //          op0        op1        n  data         hold gap ed  len ovf
      vecs[0]  = '{GATE_AND,  GATE_AND,  4, 8'b0000_0111, 0, 0, 1'b0, 4, 1'b0};
      vecs[1]  = '{GATE_XOR,  GATE_XOR,  4, 8'b0000_1101, 3, 0, 1'b1, 4, 1'b0};
      vecs[2]  = '{GATE_OR,   GATE_OR,   1, 8'b0000_0001, 0, 0, 1'b1, 1, 1'b0};
      vecs[3]  = '{GATE_OR,   GATE_OR,   1, 8'b0000_0000, 0, 0, 1'b0, 1, 1'b0};
      vecs[4]  = '{GATE_AND,  GATE_AND,  6, 8'b0011_1111, 0, 0, 1'b1, 4, 1'b1};
      vecs[5]  = '{GATE_NAND, GATE_NAND, 2, 8'b0000_0011, 0, 0, 1'b0, 2, 1'b0};
      vecs[6]  = '{GATE_NAND, GATE_NAND, 3, 8'b0000_0111, 1, 0, 1'b1, 3, 1'b0};
      vecs[7]  = '{GATE_XOR,  GATE_XOR,  5, 8'b0001_1111, 0, 0, 1'b1, 4, 1'b1};
      vecs[8]  = '{GATE_OR,   GATE_OR,   3, 8'b0000_0000, 0, 2, 1'b0, 3, 1'b0};
      vecs[9]  = '{GATE_OR,   GATE_AND,  3, 8'b0000_0100, 0, 0, 1'b1, 3, 1'b0};
      vecs[10] = '{GATE_XOR,  GATE_XOR,  4, 8'b0000_0011, 0, 0, 1'b0, 4, 1'b0};
      vecs[11] = '{GATE_AND,  GATE_AND,  5, 8'b0000_1111, 0, 0, 1'b0, 4, 1'b1};

      bus.in_valid  = 1'b0;
      bus.in_data   = 1'b0;
      bus.in_last   = 1'b0;
      bus.in_op     = 2'b00;
      bus.out_ready = 1'b0;

      // reset state
      step();
      step();
      chk("rst_ready", int'(bus.in_ready),  0);
      chk("rst_valid", int'(bus.out_valid), 0);
      chk("rst_data",  int'(bus.out_data),  0);
      chk("rst_len",   int'(bus.out_len),   0);
      chk("rst_err",   int'(bus.out_err),   0);
      rst = 1'b0;
      step();
      chk("post_rst_ready", int'(bus.in_ready), 1);

      for (int k = 0; k < 12; k++) begin
         run_vec(vecs[k], $sformatf("vec%0d", k));
      end

      // reset pulse during the 3rd beat of a 5-beat packet
      bus.out_ready = 1'b1;
      drive_beat(1'b1, 1'b0, GATE_AND);
      drive_beat(1'b1, 1'b0, GATE_AND);
      bus.in_valid = 1'b1;
      bus.in_data  = 1'b1;
      bus.in_last  = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_ready", int'(bus.in_ready),  0);
      chk("midrst_valid", int'(bus.out_valid), 0);
      chk("midrst_data",  int'(bus.out_data),  0);
      chk("midrst_len",   int'(bus.out_len),   0);
      chk("midrst_err",   int'(bus.out_err),   0);
      bus.in_valid = 1'b0;
      #1;
      rst = 1'b0;
      step();
      chk("after_rst_ready", int'(bus.in_ready),  1);
      chk("after_rst_valid", int'(bus.out_valid), 0);
      step();
      chk("no_result_valid", int'(bus.out_valid), 0);
      run_vec('{GATE_AND, GATE_AND, 2, 8'b0000_0011, 0, 0, 1'b1, 2, 1'b0}, "fresh");

      step();
      chk("sb_empty", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
